linear_layer_start_fifo_srl: RTL and testbench

//  Complete SRL-based FIFO with show-ahead read, used for start tokens and narrow scalars between dataflow

---
 rtl/linear_layer_start_fifo_srl.sv | 80 ++++++++
 tb/tb_linear_layer_start_fifo_srl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_start_fifo_srl.sv
// Shift-register FIFO with show-ahead read for start tokens and narrow scalars
// between dataflow processes of the Linear_Layer_i4xi4_q kernel.
// Writes shift into SRL[0]; the oldest word sits at SRL[count-1].
module linear_layer_start_fifo_srl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  push;
    logic                  pop;

    // Accepted transfers only; the registered flags gate the requests
    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read & if_read_ce & if_empty_n;

    // Occupancy update; simultaneous push and pop leave the count unchanged
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Count and flags; flags follow next-count so they are valid right after the edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            count      <= count_nxt;
            if_empty_n <= (count_nxt != '0);
            if_full_n  <= (count_nxt != DEPTH_C);
        end
    end

    // Shift register storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            srl[0] <= if_din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                srl[i] <= srl[i-1];
            end
        end
    end

    // Read address points at the oldest word; held at 0 while empty
    always_comb begin
        addr = '0;
        if (count != '0) begin
            addr = ADDR_WIDTH'(count - CNT_W'(1));
        end
    end

    assign if_dout   = srl[addr];
    assign occupancy = count;

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Directed bench for the SRL start FIFO: a depth-9 byte-wide instance driven
// against a queue scoreboard, plus a depth-1 instance for the degenerate case.
module tb_linear_layer_start_fifo_srl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned DP = 9;

    logic          clk = 1'b0;
    logic          reset;

    // Depth-9 instance
    logic          full_n, empty_n;
    logic          wce, wr, rce, rd;
    logic [DW-1:0] din, dout;
    logic [AW:0]   occ;

    // Depth-1 instance
    logic          full_n1, empty_n1;
    logic          wce1, wr1, rce1, rd1;
    logic [DW-1:0] din1, dout1;
    logic [1:0]    occ1;

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] sb1 [$];

    always #5 clk = ~clk;

    linear_layer_start_fifo_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset),
        .if_full_n(full_n), .if_write_ce(wce), .if_write(wr), .if_din(din),
        .if_empty_n(empty_n), .if_read_ce(rce), .if_read(rd), .if_dout(dout),
        .occupancy(occ)
    );

    linear_layer_start_fifo_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_full_n(full_n1), .if_write_ce(wce1), .if_write(wr1), .if_din(din1),
        .if_empty_n(empty_n1), .if_read_ce(rce1), .if_read(rd1), .if_dout(dout1),
        .occupancy(occ1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Flags and occupancy of the depth-9 instance against the scoreboard size
    task automatic chk_state(input string tag);
        chk({tag, "_occ"},     32'(occ),     32'(sb.size()));
        chk({tag, "_empty_n"}, 32'(empty_n), 32'(sb.size() != 0));
        chk({tag, "_full_n"},  32'(full_n),  32'(sb.size() != DP));
    endtask

    // One clock of the depth-9 instance; inputs change #1 after a rising edge
    task automatic step(input logic w, input logic w_ce, input logic [DW-1:0] d,
                        input logic r, input logic r_ce, input string tag);
        bit push_ok, pop_ok;
        wr = w; wce = w_ce; din = d; rd = r; rce = r_ce;
        push_ok = w && w_ce && (sb.size() < DP);
        pop_ok  = r && r_ce && (sb.size() > 0);
        #1;
        if (sb.size() > 0) chk({tag, "_dout"}, 32'(dout), 32'(sb[0]));
        @(posedge clk);
        #1;
        if (pop_ok)  void'(sb.pop_front());
        if (push_ok) sb.push_back(d);
        wr = 1'b0; rd = 1'b0;
    endtask

    // One clock of the depth-1 instance
    task automatic step1(input logic w, input logic w_ce, input logic [DW-1:0] d,
                         input logic r, input logic r_ce, input string tag);
        bit push_ok, pop_ok;
        wr1 = w; wce1 = w_ce; din1 = d; rd1 = r; rce1 = r_ce;
        push_ok = w && w_ce && (sb1.size() < 1);
        pop_ok  = r && r_ce && (sb1.size() > 0);
        #1;
        if (sb1.size() > 0) chk({tag, "_dout"}, 32'(dout1), 32'(sb1[0]));
        @(posedge clk);
        #1;
        if (pop_ok)  void'(sb1.pop_front());
        if (push_ok) sb1.push_back(d);
        wr1 = 1'b0; rd1 = 1'b0;
        chk({tag, "_occ"},     32'(occ1),     32'(sb1.size()));
        chk({tag, "_empty_n"}, 32'(empty_n1), 32'(sb1.size() != 0));
        chk({tag, "_full_n"},  32'(full_n1),  32'(sb1.size() != 1));
    endtask

    initial begin
        reset = 1'b1;
        wce = 1'b1; wr = 1'b0; din = '0; rce = 1'b1; rd = 1'b0;
        wce1 = 1'b1; wr1 = 1'b0; din1 = '0; rce1 = 1'b1; rd1 = 1'b0;
        #2;
        chk_state("reset");
        #20;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: fill with 1..9
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b1, DW'(i), 1'b0, 1'b1, "fill");
            chk_state("fill");
        end

        // 2: write while full is ignored, then drain in order
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, "full_wr");
        chk_state("full_wr");
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "drain");
            chk_state("drain");
        end
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "empty_rd");
        chk_state("empty_rd");

        // 3: three words then streaming push+pop
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DW'(8'h10 + i), 1'b0, 1'b1, "pre3");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, DW'(8'h20 + i), 1'b1, 1'b1, "stream");
            chk_state("stream");
        end

        // clock enables low block both directions
        step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, "ce_off");
        chk_state("ce_off");

        // 4: push+pop at full accepts only the pop
        while (sb.size() < DP) step(1'b1, 1'b1, DW'(8'h40 + sb.size()), 1'b0, 1'b1, "to_full");
        chk_state("at_full");
        step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, "pp_full");
        chk_state("pp_full");
        while (sb.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "to_empty");
        // push+pop at empty accepts only the push
        step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, "pp_empty");
        chk_state("pp_empty");
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "pp_empty_rd");
        chk_state("pp_empty_rd");

        // 5: asynchronous reset between edges with five words stored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DW'(8'h60 + i), 1'b0, 1'b1, "pre_rst");
        chk_state("pre_rst");
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        sb1.delete();
        chk_state("async_rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, "post_rst_wr");
        chk_state("post_rst_wr");
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "post_rst_rd");
        chk_state("post_rst_rd");

        // 6: depth-1 instance
        step1(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, "d1_push");
        step1(1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, "d1_push_full");
        step1(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "d1_rce_off");
        step1(1'b1, 1'b1, 8'h99, 1'b1, 1'b1, "d1_pp_full");
        step1(1'b1, 1'b0, 8'h11, 1'b0, 1'b1, "d1_wce_off");
        step1(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, "d1_pp_empty");
        step1(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "d1_pop");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
